// File: rtl/music_seq.sv
// Music sequencer: reads a register-dump track from ROM and streams one PSG register
// write per ROM byte, one frame of writes per 50/60 Hz tick.
`timescale 1ns/1ps

module music_seq #(
    parameter int ROM_WIDTH   = 17,
    parameter int REG_COUNT   = 14,
    parameter int DIV_50      = 480000,
    parameter int DIV_60      = 400000,
    parameter int ROM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           cpu_addr,
    input  logic [7:0]           cpu_din,
    input  logic                 cpu_wr,
    output logic [7:0]           cpu_dout,
    output logic [ROM_WIDTH-1:0] rom_addr,
    input  logic [7:0]           rom_data,
    output logic [3:0]           psg_addr,
    output logic [7:0]           psg_data,
    output logic                 psg_valid,
    input  logic                 psg_ready,
    output logic                 psg_reset,
    output logic                 psg_mute
);

    localparam int DIV_MAX = (DIV_50 > DIV_60) ? DIV_50 : DIV_60;
    localparam int CNT_W   = $clog2(DIV_MAX);
    localparam int LAT_W   = $clog2(ROM_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT      = LAT_W'(ROM_LATENCY);
    localparam logic [3:0]       LAST_REG = 4'(REG_COUNT - 1);

    typedef enum logic [2:0] {IDLE, HDR, SKIP, WAITFRAME, FETCH, WRITE} state_t;

    function automatic logic [7:0] reg_mask(input logic [3:0] r);
        case (r)
            4'd0, 4'd2, 4'd4, 4'd7, 4'd11, 4'd12: reg_mask = 8'hFF;
            4'd1, 4'd3, 4'd5, 4'd13:              reg_mask = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10:              reg_mask = 8'h1F;
            default:                              reg_mask = 8'h00;
        endcase
    endfunction

    // Header fields are visited in this order: length hi/lo, flags, rate, loop hi/lo.
    function automatic logic [7:0] hdr_offset(input logic [2:0] i);
        case (i)
            3'd0:    hdr_offset = 8'h0E;
            3'd1:    hdr_offset = 8'h0F;
            3'd2:    hdr_offset = 8'h13;
            3'd3:    hdr_offset = 8'h1B;
            3'd4:    hdr_offset = 8'h1E;
            3'd5:    hdr_offset = 8'h1F;
            default: hdr_offset = 8'h0E;
        endcase
    endfunction

    function automatic logic [ROM_WIDTH-1:0] frame_addr(
        input logic [ROM_WIDTH-1:0] b,
        input logic [ROM_WIDTH-1:0] ff,
        input logic                 il,
        input logic [14:0]          len,
        input logic [14:0]          f,
        input logic [3:0]           r
    );
        logic [31:0] sum;
        sum = 32'(b) + 32'(ff) + (il ? (32'(r) * 32'(len) + 32'(f))
                                     : (32'(f) * 32'd16 + 32'(r)));
        frame_addr = sum[ROM_WIDTH-1:0];
    endfunction

    state_t                state_r, state_n;
    logic [ROM_WIDTH-1:0]  base_r, base_n;
    logic [1:0]            ovr_r, ovr_n;
    logic                  playing_r, playing_n;
    logic                  loop_r, loop_n;
    logic                  paused_r, paused_n;
    logic                  overrun_r, overrun_n;
    logic                  tick_pending_r, tick_pending_n;
    logic [CNT_W-1:0]      div_cnt_r, div_cnt_n;
    logic [ROM_WIDTH-1:0]  rom_addr_r, rom_addr_n;
    logic [LAT_W-1:0]      wait_r, wait_n;
    logic [2:0]            hdr_idx_r, hdr_idx_n;
    logic [1:0]            nul_cnt_r, nul_cnt_n;
    logic                  interleave_r, interleave_n;
    logic                  rate50_r, rate50_n;
    logic [14:0]           length_r, length_n;
    logic [14:0]           loop_pt_r, loop_pt_n;
    logic [ROM_WIDTH-1:0]  first_frame_r, first_frame_n;
    logic [14:0]           frame_r, frame_n;
    logic [3:0]            reg_idx_r, reg_idx_n;
    logic                  psg_valid_r, psg_valid_n;
    logic [3:0]            psg_addr_r, psg_addr_n;
    logic [7:0]            psg_data_r, psg_data_n;

    logic [23:0]           base_wide_s;
    logic                  use50_s;
    logic [CNT_W-1:0]      period_m1_s;
    logic                  tick_s;
    logic                  consume_s;

    assign base_wide_s = 24'(base_r);
    assign use50_s     = (ovr_r == 2'd1) | ((ovr_r != 2'd2) & rate50_r);
    assign period_m1_s = use50_s ? CNT_W'(DIV_50 - 1) : CNT_W'(DIV_60 - 1);
    assign tick_s      = (state_r != IDLE) && (div_cnt_r >= period_m1_s);

    // Next-state, datapath and CPU command decode; CPU commands are applied last so they win.
    always_comb begin
        state_n        = state_r;
        base_n         = base_r;
        ovr_n          = ovr_r;
        playing_n      = playing_r;
        loop_n         = loop_r;
        paused_n       = paused_r;
        overrun_n      = overrun_r;
        tick_pending_n = tick_pending_r;
        rom_addr_n     = rom_addr_r;
        hdr_idx_n      = hdr_idx_r;
        nul_cnt_n      = nul_cnt_r;
        interleave_n   = interleave_r;
        rate50_n       = rate50_r;
        length_n       = length_r;
        loop_pt_n      = loop_pt_r;
        first_frame_n  = first_frame_r;
        frame_n        = frame_r;
        reg_idx_n      = reg_idx_r;
        psg_valid_n    = psg_valid_r;
        psg_addr_n     = psg_addr_r;
        psg_data_n     = psg_data_r;
        consume_s      = 1'b0;

        if (wait_r != '0) begin
            wait_n = wait_r - LAT_W'(1);
        end else begin
            wait_n = wait_r;
        end

        if ((state_r == IDLE) || tick_s) begin
            div_cnt_n = '0;
        end else begin
            div_cnt_n = div_cnt_r + CNT_W'(1);
        end

        case (state_r)
            IDLE: begin
                state_n = IDLE;
            end
            HDR: begin
                if (wait_r == '0) begin
                    case (hdr_idx_r)
                        3'd0:    length_n[14:8]  = rom_data[6:0];
                        3'd1:    length_n[7:0]   = rom_data;
                        3'd2:    interleave_n    = rom_data[0];
                        3'd3:    rate50_n        = (rom_data == 8'd50);
                        3'd4:    loop_pt_n[14:8] = rom_data[6:0];
                        3'd5:    loop_pt_n[7:0]  = rom_data;
                        default: hdr_idx_n       = 3'd0;
                    endcase
                    if (hdr_idx_r != 3'd5) begin
                        hdr_idx_n  = hdr_idx_r + 3'd1;
                        rom_addr_n = base_r + ROM_WIDTH'(hdr_offset(hdr_idx_r + 3'd1));
                    end else begin
                        state_n    = SKIP;
                        nul_cnt_n  = 2'd0;
                        rom_addr_n = base_r + ROM_WIDTH'(8'h22);
                    end
                    wait_n = LAT;
                end else begin
                    state_n = HDR;
                end
            end
            SKIP: begin
                if (wait_r == '0) begin
                    rom_addr_n = rom_addr_r + ROM_WIDTH'(1);
                    wait_n     = LAT;
                    if (rom_data == 8'h00) begin
                        if (nul_cnt_r == 2'd2) begin
                            // Frame data starts right after the third string terminator.
                            first_frame_n = rom_addr_r + ROM_WIDTH'(1) - base_r;
                            frame_n       = 15'd0;
                            if (loop_pt_r >= length_r) begin
                                loop_pt_n = 15'd0;
                            end else begin
                                loop_pt_n = loop_pt_r;
                            end
                            if (length_r == 15'd0) begin
                                state_n   = IDLE;
                                playing_n = 1'b0;
                            end else begin
                                state_n = WAITFRAME;
                            end
                        end else begin
                            nul_cnt_n = nul_cnt_r + 2'd1;
                        end
                    end else begin
                        nul_cnt_n = nul_cnt_r;
                    end
                end else begin
                    state_n = SKIP;
                end
            end
            WAITFRAME: begin
                if (tick_pending_r && !paused_r) begin
                    consume_s      = 1'b1;
                    tick_pending_n = 1'b0;
                    reg_idx_n      = 4'd0;
                    state_n        = FETCH;
                    rom_addr_n     = frame_addr(base_r, first_frame_r, interleave_r,
                                                length_r, frame_r, 4'd0);
                    wait_n         = LAT;
                end else begin
                    state_n = WAITFRAME;
                end
            end
            FETCH: begin
                if (wait_r == '0) begin
                    psg_addr_n  = reg_idx_r;
                    psg_data_n  = rom_data & reg_mask(reg_idx_r);
                    psg_valid_n = 1'b1;
                    state_n     = WRITE;
                end else begin
                    state_n = FETCH;
                end
            end
            WRITE: begin
                if (psg_ready) begin
                    psg_valid_n = 1'b0;
                    if (reg_idx_r < LAST_REG) begin
                        reg_idx_n  = reg_idx_r + 4'd1;
                        state_n    = FETCH;
                        rom_addr_n = frame_addr(base_r, first_frame_r, interleave_r,
                                                length_r, frame_r, reg_idx_r + 4'd1);
                        wait_n     = LAT;
                    end else if (frame_r + 15'd1 == length_r) begin
                        if (loop_r) begin
                            frame_n = loop_pt_r;
                            state_n = WAITFRAME;
                        end else begin
                            playing_n = 1'b0;
                            paused_n  = 1'b0;
                            state_n   = IDLE;
                        end
                    end else begin
                        frame_n = frame_r + 15'd1;
                        state_n = WAITFRAME;
                    end
                end else begin
                    state_n = WRITE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A tick arriving while one is still pending is lost and flagged.
        if (tick_s) begin
            if (tick_pending_r && !consume_s) begin
                overrun_n = 1'b1;
            end else begin
                overrun_n = overrun_r;
            end
            tick_pending_n = 1'b1;
        end else begin
            tick_pending_n = tick_pending_n;
        end

        if (cpu_wr) begin
            case (cpu_addr)
                3'd0: begin
                    case (cpu_din)
                        8'd1, 8'd2: begin
                            state_n        = HDR;
                            hdr_idx_n      = 3'd0;
                            rom_addr_n     = base_r + ROM_WIDTH'(8'h0E);
                            wait_n         = LAT;
                            psg_valid_n    = 1'b0;
                            paused_n       = 1'b0;
                            overrun_n      = 1'b0;
                            playing_n      = 1'b1;
                            loop_n         = (cpu_din == 8'd2);
                            tick_pending_n = 1'b0;
                            div_cnt_n      = '0;
                        end
                        8'd3: begin
                            state_n     = IDLE;
                            psg_valid_n = 1'b0;
                            playing_n   = 1'b0;
                            paused_n    = 1'b0;
                            loop_n      = 1'b0;
                        end
                        8'd4:    paused_n = playing_r;
                        8'd5:    paused_n = 1'b0;
                        default: paused_n = paused_n;
                    endcase
                end
                3'd1:    base_n = ROM_WIDTH'({cpu_din, base_wide_s[15:0]});
                3'd2:    base_n = ROM_WIDTH'({base_wide_s[23:16], cpu_din, base_wide_s[7:0]});
                3'd3:    base_n = ROM_WIDTH'({base_wide_s[23:8], cpu_din});
                3'd4:    ovr_n  = cpu_din[1:0];
                default: ovr_n  = ovr_n;
            endcase
        end else begin
            ovr_n = ovr_n;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            base_r         <= '0;
            ovr_r          <= 2'd0;
            playing_r      <= 1'b0;
            loop_r         <= 1'b0;
            paused_r       <= 1'b0;
            overrun_r      <= 1'b0;
            tick_pending_r <= 1'b0;
            div_cnt_r      <= '0;
            rom_addr_r     <= '0;
            wait_r         <= '0;
            hdr_idx_r      <= 3'd0;
            nul_cnt_r      <= 2'd0;
            interleave_r   <= 1'b0;
            rate50_r       <= 1'b0;
            length_r       <= 15'd0;
            loop_pt_r      <= 15'd0;
            first_frame_r  <= '0;
            frame_r        <= 15'd0;
            reg_idx_r      <= 4'd0;
            psg_valid_r    <= 1'b0;
            psg_addr_r     <= 4'd0;
            psg_data_r     <= 8'd0;
        end else begin
            state_r        <= state_n;
            base_r         <= base_n;
            ovr_r          <= ovr_n;
            playing_r      <= playing_n;
            loop_r         <= loop_n;
            paused_r       <= paused_n;
            overrun_r      <= overrun_n;
            tick_pending_r <= tick_pending_n;
            div_cnt_r      <= div_cnt_n;
            rom_addr_r     <= rom_addr_n;
            wait_r         <= wait_n;
            hdr_idx_r      <= hdr_idx_n;
            nul_cnt_r      <= nul_cnt_n;
            interleave_r   <= interleave_n;
            rate50_r       <= rate50_n;
            length_r       <= length_n;
            loop_pt_r      <= loop_pt_n;
            first_frame_r  <= first_frame_n;
            frame_r        <= frame_n;
            reg_idx_r      <= reg_idx_n;
            psg_valid_r    <= psg_valid_n;
            psg_addr_r     <= psg_addr_n;
            psg_data_r     <= psg_data_n;
        end
    end

    // CPU read mux.
    always_comb begin
        case (cpu_addr)
            3'd0:    cpu_dout = {4'b0000, overrun_r, paused_r, loop_r, playing_r};
            3'd1:    cpu_dout = base_wide_s[23:16];
            3'd2:    cpu_dout = base_wide_s[15:8];
            3'd3:    cpu_dout = base_wide_s[7:0];
            3'd4:    cpu_dout = {6'b000000, ovr_r};
            3'd5:    cpu_dout = frame_r[7:0];
            3'd6:    cpu_dout = {1'b0, frame_r[14:8]};
            default: cpu_dout = 8'h00;
        endcase
    end

    assign rom_addr  = rom_addr_r;
    assign psg_addr  = psg_addr_r;
    assign psg_data  = psg_data_r;
    assign psg_valid = psg_valid_r;
    assign psg_reset = reset | (state_r == IDLE);
    assign psg_mute  = paused_r;

endmodule

// File: doc/music_seq.md
MUSIC_SEQ -- requirements
Module: music_seq

Interface
REQ-001 SHALL take parameter ROM_WIDTH, default 17, music ROM address width.
REQ-002 SHALL take parameter REG_COUNT, default 14, PSG registers written per frame (range 14..16).
REQ-003 SHALL take parameter DIV_50, default 480000, clocks per 50 Hz frame.
REQ-004 SHALL take parameter DIV_60, default 400000, clocks per 60 Hz frame.
REQ-005 SHALL take parameter ROM_LATENCY, default 1, cycles from rom_addr change to valid rom_data (1..3).
REQ-006 SHALL have the port clk, input, 1 bit, system clock; reset, input, 1 bit, synchronous, active-high.
REQ-007 SHALL have the ports cpu_addr (input, 3, register select), cpu_din (input, 8, write data), cpu_wr (input, 1, write strobe) and cpu_dout (output, 8, combinational read data).
REQ-008 SHALL have the ports rom_addr (output, ROM_WIDTH, registered ROM address) and rom_data (input, 8, ROM data).
REQ-009 SHALL have the ports psg_addr (output, 4), psg_data (output, 8), psg_valid (output, 1) and psg_ready (input, 1): a valid/ready PSG register-write channel.
REQ-010 SHALL have the ports psg_reset (output, 1, holds the PSG in reset) and psg_mute (output, 1, high while paused).

Function
REQ-011 SHALL use this register map: 0 = command write / status read {4'b0, overrun, paused, loop, playing}; 1/2/3 = track base address bytes hi/mid/lo (truncated to ROM_WIDTH); 4 = rate override (0 = header, 1 = force 50 Hz, 2 = force 60 Hz); 5/6 = current frame lo/hi (read-only); 7 = reads 0.
REQ-012 SHALL implement these commands: 1 = play once, 2 = play looped, 3 = stop, 4 = pause, 5 = resume; all other values are ignored; a command takes effect on the cycle after the write.
REQ-013 SHALL, on play or loop, abort any in-flight activity (psg_valid low), clear paused and overrun, set playing, set loop per command and enter HDR.
REQ-014 SHALL, on stop, clear playing, paused and loop, and enter IDLE.
REQ-015 SHALL implement these states: IDLE, HDR, SKIP, WAITFRAME, FETCH, WRITE; psg_reset = 1 exactly when in IDLE or when reset is asserted.
REQ-016 SHALL apply ROM_LATENCY wait cycles after every rom_addr change before sampling rom_data.
REQ-017 SHALL, in HDR, read at base+offset: 0x13 bit0 = interleave; 0x0E[6:0]:0x0F = length (15 bits); 0x1B == 50 selects 50 Hz, otherwise 60 Hz; 0x1E[6:0]:0x1F = loop point.
REQ-018 SHALL, in SKIP, scan from base+0x22 past three NUL-terminated strings; first_frame = (address after the third NUL) - base; then enter WAITFRAME with frame = 0.
REQ-019 SHALL, if length == 0, clear playing and enter IDLE at the end of SKIP; if loop point >= length, use 0 as the loop point.
REQ-020 SHALL run a free-running frame divider with period DIV_50 or DIV_60 (selected by override or header), setting a one-deep tick_pending flag on each tick.
REQ-021 SHALL, if a tick arrives while tick_pending is already set, drop the tick and set the sticky overrun bit.
REQ-022 SHALL, in WAITFRAME with tick_pending set and paused clear, clear tick_pending and enter FETCH with reg = 0; while paused, ticks SHALL still set tick_pending but SHALL NOT be consumed.
REQ-023 SHALL compute the FETCH address as base + first_frame + reg*length + frame (interleaved) or base + first_frame + frame*16 + reg (non-interleaved), modulo 2^ROM_WIDTH.
REQ-024 SHALL, in WRITE, hold psg_valid = 1, psg_addr = reg and psg_data = rom_data & mask[reg] stable until psg_ready; transfer occurs on a cycle where valid and ready are both high.
REQ-025 SHALL use masks for regs 0..15: FF,0F,FF,0F,FF,0F,1F,FF,1F,1F,1F,FF,FF,0F,00,00.
REQ-026 SHALL, after a transfer with reg < REG_COUNT-1, increment reg and go to FETCH; otherwise increment frame and go to WAITFRAME.
REQ-027 SHALL, when frame+1 == length: if loop is set, set frame = loop point; otherwise clear playing and enter IDLE.
REQ-028 SHALL, when a CPU command and end-of-song coincide, give the CPU command priority.
REQ-029 SHALL, when pause is written mid-frame, finish the current frame's writes before holding in WAITFRAME.

Reset
REQ-030 SHALL, on reset, clear all registers, enter IDLE and drive psg_valid = 0, psg_reset = 1, psg_mute = 0, rom_addr = 0 and cpu_dout per a cleared map; reset mid-operation SHALL abandon any pending PSG write.

Verification
REQ-031 SHALL verify: non-interleaved track at base 0x100, length 2, 50 Hz, play once -> 28 writes with correct masks, then status = 0x00 and psg_reset = 1.
REQ-032 SHALL verify: interleaved track, length 3, loop point 1, loop -> frame sequence 0,1,2,1,2 and reg r read at base+ff+r*3+f.
REQ-033 SHALL verify: psg_ready held low for 10 cycles during a write -> psg_addr/psg_data stable, and a second tick sets overrun (status bit3 = 1).
REQ-034 SHALL verify: pause mid-frame -> the frame completes, psg_mute = 1 and no writes follow; resume -> the next frame is written on the pending tick.
REQ-035 SHALL verify: header with length = 0 -> no PSG writes and playing clears; override 2 on a 50 Hz header -> ticks every DIV_60 clocks.
REQ-036 SHALL verify: reset asserted during WRITE -> psg_valid = 0 on the next cycle and status = 0x00.
